// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: op codes and the arbitration FSM states.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// with wrap-around, as both an index and a one-hot vector.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [1:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       grant_idx,
    output logic             any_valid
);

    logic [3:0] valid_ext;
    logic [1:0] idx;

    // Scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        valid_ext            = '0;
        valid_ext[N_REQ-1:0] = valid;
        grant_idx            = '0;
        any_valid            = 1'b0;
        idx                  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = 2'((int'(ptr) + k) % N_REQ);
            if (valid_ext[idx]) begin
                grant_idx = idx;
                any_valid = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
        assign grant[gi] = any_valid && (grant_idx == 2'(gi));
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between up to four requesters.
// One operation in flight: grant (IDLE) -> compute (EXEC) -> hold result (RESP).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_srcA,
    input  logic [32*N_REQ-1:0]   req_srcB,
    input  logic [3*N_REQ-1:0]    req_op,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  rsp_zero,
    output logic [31:0]           alu_srcA,
    output logic [31:0]           alu_srcB,
    output logic [2:0]            alu_control,
    input  logic [31:0]           alu_result,
    input  logic                  alu_zero,
    output logic                  busy,
    output logic [1:0]            grant_id
);

    if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
        $error("alu_arbiter: N_REQ must be in 2..4");
    end

    arb_state_t        state_reg;
    logic [1:0]        rr_ptr_reg;
    logic [1:0]        grant_id_reg;
    logic [31:0]       op_a_reg;
    logic [31:0]       op_b_reg;
    alu_op_t           op_reg;
    logic [31:0]       result_reg;
    logic              zero_reg;
    logic [N_REQ-1:0]  rsp_valid_reg;

    logic [N_REQ-1:0]  arb_grant;
    logic [1:0]        arb_idx;
    logic              arb_any;
    logic [1:0]        rr_ptr_next;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    alu_op_t           sel_op;
    logic [N_REQ-1:0]  owner_onehot;
    logic              accept;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    // Operand mux for the requester the picker has chosen.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ALU_AND;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == 2'(i)) begin
                sel_a  = req_srcA[32*i +: 32];
                sel_b  = req_srcB[32*i +: 32];
                sel_op = alu_op_t'(req_op[3*i +: 3]);
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_owner
        assign owner_onehot[gi] = (grant_id_reg == 2'(gi));
    end

    assign rr_ptr_next = (arb_idx == 2'(N_REQ - 1)) ? 2'd0 : arb_idx + 2'd1;
    // Only the owner's rsp_ready can release the held result.
    assign accept      = |(rsp_ready & owner_onehot);

    // Arbitration FSM with operand, result and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_id_reg  <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            op_reg        <= ALU_AND;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            rsp_valid_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        op_a_reg     <= sel_a;
                        op_b_reg     <= sel_b;
                        op_reg       <= sel_op;
                        grant_id_reg <= arb_idx;
                        rr_ptr_reg   <= rr_ptr_next;
                        state_reg    <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg    <= alu_result;
                    zero_reg      <= alu_zero;
                    rsp_valid_reg <= owner_onehot;
                    state_reg     <= RESP;
                end
                RESP: begin
                    // No grant here even on accept: next grant is from IDLE.
                    if (accept) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // req_ready is forced low while reset is held so nothing looks accepted.
    assign req_ready   = (state_reg == IDLE && rst_n) ? arb_grant : '0;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_result  = result_reg;
    assign rsp_zero    = zero_reg;
    assign alu_srcA    = op_a_reg;
    assign alu_srcB    = op_b_reg;
    assign alu_control = op_reg;
    assign busy        = (state_reg != IDLE);
    assign grant_id    = grant_id_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: an N_REQ=2 and an N_REQ=4 arbiter run side by side,
// each against a transaction-level model and hand-computed expectations.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   valid  [2];
    logic [127:0] srca   [2];
    logic [127:0] srcb   [2];
    logic [11:0]  opc    [2];
    logic [3:0]   rready [2];

    // N_REQ=2 instance signals
    logic [1:0]  a_req_ready, a_rsp_valid, a_grant_id;
    logic [31:0] a_rsp_result, a_alu_srcA, a_alu_srcB, a_alu_result;
    logic        a_rsp_zero, a_busy, a_alu_zero;
    logic [2:0]  a_alu_control;
    // N_REQ=4 instance signals
    logic [3:0]  b_req_ready, b_rsp_valid;
    logic [1:0]  b_grant_id;
    logic [31:0] b_rsp_result, b_alu_srcA, b_alu_srcB, b_alu_result;
    logic        b_rsp_zero, b_busy, b_alu_zero;
    logic [2:0]  b_alu_control;

    function automatic logic [32:0] alu_f(logic [2:0] op, logic [31:0] x, logic [31:0] y);
        logic [31:0] r;
        case (op)
            3'b010:  r = x + y;
            3'b110:  r = x - y;
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b111:  r = (x < y) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    assign {a_alu_zero, a_alu_result} = alu_f(a_alu_control, a_alu_srcA, a_alu_srcB);
    assign {b_alu_zero, b_alu_result} = alu_f(b_alu_control, b_alu_srcA, b_alu_srcB);

    alu_arbiter #(.N_REQ(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid[0][1:0]), .req_ready(a_req_ready),
        .req_srcA(srca[0][63:0]), .req_srcB(srcb[0][63:0]), .req_op(opc[0][5:0]),
        .rsp_valid(a_rsp_valid), .rsp_ready(rready[0][1:0]),
        .rsp_result(a_rsp_result), .rsp_zero(a_rsp_zero),
        .alu_srcA(a_alu_srcA), .alu_srcB(a_alu_srcB), .alu_control(a_alu_control),
        .alu_result(a_alu_result), .alu_zero(a_alu_zero),
        .busy(a_busy), .grant_id(a_grant_id)
    );

    alu_arbiter #(.N_REQ(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid[1]), .req_ready(b_req_ready),
        .req_srcA(srca[1]), .req_srcB(srcb[1]), .req_op(opc[1]),
        .rsp_valid(b_rsp_valid), .rsp_ready(rready[1]),
        .rsp_result(b_rsp_result), .rsp_zero(b_rsp_zero),
        .alu_srcA(b_alu_srcA), .alu_srcB(b_alu_srcB), .alu_control(b_alu_control),
        .alu_result(b_alu_result), .alu_zero(b_alu_zero),
        .busy(b_busy), .grant_id(b_grant_id)
    );

    // Requester-side queues of pending operations, index d*4+i.
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } rq_t;
    rq_t rq [8][$];

    // Transaction model: age counts cycles since grant (0 = no operation).
    typedef struct {
        int          ptr;
        int          gid;
        int          age;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        z;
    } mdl_t;
    mdl_t m [2];

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          gidx [2][$];
    int          gcyc [2][$];
    int          acyc [2][$];
    logic [32:0] rlog [2][$];
    int          busy_cnt [2];
    int          rv_cnt   [2];
    int          rv_first [2];

    function automatic int nreq(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int pick(int d);
        for (int k = 0; k < nreq(d); k++) begin
            int i;
            i = (m[d].ptr + k) % nreq(d);
            if (valid[d][i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(string nm, int d, logic [32:0] act, logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h, required 0x%0h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic mreset(int d);
        m[d].ptr = 0; m[d].gid = 0; m[d].age = 0;
        m[d].a = '0; m[d].b = '0; m[d].op = '0; m[d].res = '0; m[d].z = 1'b0;
    endtask

    task automatic push(int d, int i, logic [31:0] a, logic [31:0] b, logic [2:0] op);
        rq_t e;
        e.a = a; e.b = b; e.op = op;
        rq[d*4+i].push_back(e);
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (i < nreq(d) && rq[d*4+i].size() > 0) begin
                    valid[d][i]          = 1'b1;
                    srca[d][32*i +: 32]  = rq[d*4+i][0].a;
                    srcb[d][32*i +: 32]  = rq[d*4+i][0].b;
                    opc[d][3*i +: 3]     = rq[d*4+i][0].op;
                end else begin
                    valid[d][i]          = 1'b0;
                end
            end
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            gidx[d].delete(); gcyc[d].delete(); acyc[d].delete(); rlog[d].delete();
            busy_cnt[d] = 0; rv_cnt[d] = 0; rv_first[d] = -1;
        end
    endtask

    // One clock cycle: compare every output against the model at negedge,
    // log what happened, advance the model, then update requesters after posedge.
    task automatic tick();
        int granted [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic [3:0]  o_rr, o_rv, e_rr, e_rv;
            logic [31:0] o_res, o_a, o_b;
            logic        o_z, o_busy;
            logic [2:0]  o_ctl;
            logic [1:0]  o_gid;
            logic [32:0] nr;
            int g;
            granted[d] = -1;
            if (d == 0) begin
                o_rr = {2'b00, a_req_ready}; o_rv = {2'b00, a_rsp_valid};
                o_res = a_rsp_result; o_z = a_rsp_zero; o_a = a_alu_srcA; o_b = a_alu_srcB;
                o_ctl = a_alu_control; o_busy = a_busy; o_gid = a_grant_id;
            end else begin
                o_rr = b_req_ready; o_rv = b_rsp_valid;
                o_res = b_rsp_result; o_z = b_rsp_zero; o_a = b_alu_srcA; o_b = b_alu_srcB;
                o_ctl = b_alu_control; o_busy = b_busy; o_gid = b_grant_id;
            end
            if (!rst_n) mreset(d);
            g    = pick(d);
            e_rr = (rst_n && m[d].age == 0 && g >= 0) ? 4'(1 << g) : 4'b0;
            e_rv = (m[d].age == 2) ? 4'(1 << m[d].gid) : 4'b0;
            chk("req_ready",   d, 33'(o_rr),   33'(e_rr));
            chk("rsp_valid",   d, 33'(o_rv),   33'(e_rv));
            chk("rsp_result",  d, 33'(o_res),  33'(m[d].res));
            chk("rsp_zero",    d, 33'(o_z),    33'(m[d].z));
            chk("alu_srcA",    d, 33'(o_a),    33'(m[d].a));
            chk("alu_srcB",    d, 33'(o_b),    33'(m[d].b));
            chk("alu_control", d, 33'(o_ctl),  33'(m[d].op));
            chk("busy",        d, 33'(o_busy), 33'(m[d].age != 0));
            chk("grant_id",    d, 33'(o_gid),  33'(m[d].gid));
            for (int i = 0; i < 4; i++) begin
                if (o_rr[i]) begin
                    gidx[d].push_back(i);
                    gcyc[d].push_back(cyc);
                end
            end
            if (o_busy) busy_cnt[d]++;
            if (o_rv != 4'b0) begin
                rv_cnt[d]++;
                if (rv_first[d] < 0) rv_first[d] = cyc;
            end
            if ((o_rv & rready[d]) != 4'b0) begin
                rlog[d].push_back({o_z, o_res});
                acyc[d].push_back(cyc);
            end
            if (rst_n) begin
                if (m[d].age == 0) begin
                    if (g >= 0) begin
                        m[d].a   = srca[d][32*g +: 32];
                        m[d].b   = srcb[d][32*g +: 32];
                        m[d].op  = opc[d][3*g +: 3];
                        m[d].gid = g;
                        m[d].ptr = (g + 1) % nreq(d);
                        m[d].age = 1;
                        granted[d] = g;
                    end
                end else if (m[d].age == 1) begin
                    nr       = alu_f(m[d].op, m[d].a, m[d].b);
                    m[d].res = nr[31:0];
                    m[d].z   = nr[32];
                    m[d].age = 2;
                end else begin
                    if (rready[d][m[d].gid]) m[d].age = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (granted[d] >= 0) void'(rq[d*4+granted[d]].pop_front());
        end
        drive();
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int exp_g [4];
        logic [32:0] exp_r [4];
        n_checks = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            valid[d] = '0; srca[d] = '0; srcb[d] = '0; opc[d] = '0; rready[d] = 4'hF;
            mreset(d);
        end
        clear_logs();
        run(2);
        chk("reset_busy", 0, 33'(a_busy), 33'(0));
        chk("reset_rsp_valid", 1, 33'(b_rsp_valid), 33'(0));
        rst_n = 1'b1;
        run(1);

        // Single ADD 5+7 from requester 0
        clear_logs();
        for (int d = 0; d < 2; d++) push(d, 0, 32'd5, 32'd7, 3'b010);
        drive();
        run(6);
        for (int d = 0; d < 2; d++) begin
            chk("single_n_grants", d, 33'(gidx[d].size()), 33'(1));
            chk("single_grant", d, 33'((gidx[d].size() > 0) ? gidx[d][0] : -1), 33'(0));
            chk("single_latency", d, 33'((gcyc[d].size() > 0) ? rv_first[d] - gcyc[d][0] : -1), 33'(2));
            chk("single_result", d, (rlog[d].size() > 0) ? rlog[d][0] : 33'h1FFFFFFFF, {1'b0, 32'd12});
            chk("single_busy_cycles", d, 33'(busy_cnt[d]), 33'(2));
        end

        // SLT 3<4 then illegal op 011 from requester 1
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            push(d, 1, 32'd3, 32'd4, 3'b111);
            push(d, 1, 32'd5, 32'd9, 3'b011);
        end
        drive();
        run(10);
        for (int d = 0; d < 2; d++) begin
            chk("slt_result", d, (rlog[d].size() > 0) ? rlog[d][0] : 33'h1FFFFFFFF, {1'b0, 32'd1});
            chk("illegal_result", d, (rlog[d].size() > 1) ? rlog[d][1] : 33'h1FFFFFFFF, {1'b1, 32'd0});
        end

        // Reset pulse while requester 0's operation is in EXEC
        for (int d = 0; d < 2; d++) push(d, 0, 32'd1, 32'd1, 3'b010);
        drive();
        run(1);
        clear_logs();
        chk("pre_reset_busy", 0, 33'(a_busy), 33'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 0, 33'(a_busy), 33'(0));
        chk("rst_busy", 1, 33'(b_busy), 33'(0));
        chk("rst_alu_srcA", 0, 33'(a_alu_srcA), 33'(0));
        chk("rst_alu_control", 1, 33'(b_alu_control), 33'(0));
        chk("rst_rsp_zero", 0, 33'(a_rsp_zero), 33'(0));
        chk("rst_grant_id", 1, 33'(b_grant_id), 33'(0));
        run(1);
        rst_n = 1'b1;
        run(4);
        for (int d = 0; d < 2; d++) chk("rst_no_response", d, 33'(rv_cnt[d]), 33'(0));

        // Contention: req 0 SUB 9-9, req 1 OR F0|0F, both held continuously
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                push(d, 0, 32'd9, 32'd9, 3'b110);
                push(d, 1, 32'hF0, 32'h0F, 3'b001);
            end
        end
        drive();
        run(16);
        exp_g = '{0, 1, 0, 1};
        exp_r = '{{1'b1, 32'd0}, {1'b0, 32'hFF}, {1'b1, 32'd0}, {1'b0, 32'hFF}};
        for (int d = 0; d < 2; d++) begin
            chk("cont_n_results", d, 33'(rlog[d].size()), 33'(4));
            for (int k = 0; k < 4; k++) begin
                chk("cont_grant", d, 33'((gidx[d].size() > k) ? gidx[d][k] : -1), 33'(exp_g[k]));
                chk("cont_result", d, (rlog[d].size() > k) ? rlog[d][k] : 33'h1FFFFFFFF, exp_r[k]);
            end
        end

        // Backpressure: requester 0 withholds rsp_ready for 5 cycles
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            rready[d][0] = 1'b0;
            push(d, 0, 32'd1, 32'd2, 3'b010);
            push(d, 1, 32'hC, 32'hA, 3'b000);
        end
        drive();
        run(2);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 0, 33'(a_rsp_valid), 33'(2'b01));
            chk("bp_rsp_result", 0, 33'(a_rsp_result), 33'(3));
            chk("bp_req_ready", 0, 33'(a_req_ready), 33'(0));
            chk("bp_rsp_valid", 1, 33'(b_rsp_valid), 33'(4'b0001));
            chk("bp_req_ready", 1, 33'(b_req_ready), 33'(0));
            tick();
        end
        for (int d = 0; d < 2; d++) rready[d][0] = 1'b1;
        run(7);
        for (int d = 0; d < 2; d++) begin
            chk("bp_second_grant", d, 33'((gidx[d].size() > 1) ? gidx[d][1] : -1), 33'(1));
            chk("bp_grant_after_accept", d,
                33'((gcyc[d].size() > 1 && acyc[d].size() > 0) ? gcyc[d][1] - acyc[d][0] : -1), 33'(1));
            chk("bp_first_result", d, (rlog[d].size() > 0) ? rlog[d][0] : 33'h1FFFFFFFF, {1'b0, 32'd3});
            chk("bp_second_result", d, (rlog[d].size() > 1) ? rlog[d][1] : 33'h1FFFFFFFF, {1'b0, 32'd8});
        end

        // Wrap-around on the 4-requester instance: move pointer to 3, then 3 and 0 contend
        clear_logs();
        push(1, 2, 32'd2, 32'd3, 3'b010);
        drive();
        run(5);
        push(1, 3, 32'd7, 32'd0, 3'b001);
        push(1, 0, 32'd4, 32'd4, 3'b110);
        drive();
        run(10);
        chk("wrap_n_grants", 1, 33'(gidx[1].size()), 33'(3));
        chk("wrap_grant_a", 1, 33'((gidx[1].size() > 1) ? gidx[1][1] : -1), 33'(3));
        chk("wrap_grant_b", 1, 33'((gidx[1].size() > 2) ? gidx[1][2] : -1), 33'(0));
        chk("wrap_result", 1, (rlog[1].size() > 2) ? rlog[1][2] : 33'h1FFFFFFFF, {1'b1, 32'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between up to four requesters (e.g. execute stage, address generator, branch comparator) using round-robin arbitration. It applies valid/ready handshakes on both the request and response sides, and registers each ALU result until the owning requester accepts it. One operation is outstanding at a time. The block sits between the requesters and the ALU's srcA/srcB/ALU_control/ALU_result/zero ports.

## Interface

Parameters:
- N_REQ, default 2: number of requesters, legal range 2..4.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accepted; one-hot or zero.
- req_srcA  in  32*N_REQ  packed operand A; requester i is at bits [32i+31:32i].
- req_srcB  in  32*N_REQ  packed operand B, same packing as req_srcA.
- req_op  in  3*N_REQ  packed ALU op code; requester i is at bits [3i+2:3i].
- rsp_valid  out  N_REQ  per-requester result valid; one-hot or zero.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_result  out  32  result, shared by all requesters; valid only for the requester whose rsp_valid is high.
- rsp_zero  out  1  registered ALU zero flag.
- alu_srcA  out  32  drives the ALU srcA input.
- alu_srcB  out  32  drives the ALU srcB input.
- alu_control  out  3  drives the ALU control input.
- alu_result  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  2  index of the current or most recent owner.

## Operation

FSM states: IDLE, EXEC, RESP.

IDLE:
- The round-robin picker selects the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
- req_ready[g]=1 is asserted combinationally in the same cycle.
- At the clock edge: latch req_srcA/B[g] and req_op[g] into the operand registers, set grant_id=g and rr_ptr=(g+1) mod N_REQ, and go to EXEC.
- If no requester is valid, stay in IDLE; rr_ptr is unchanged.

EXEC:
- alu_srcA/alu_srcB/alu_control are driven from the operand registers.
- At the edge: capture alu_result into rsp_result and alu_zero into rsp_zero, set rsp_valid[grant_id]=1, and go to RESP.

RESP:
- Hold rsp_valid[grant_id] and the result stable until rsp_ready[grant_id]=1.
- At that edge, clear rsp_valid and go to IDLE.
- rsp_ready from any other requester is ignored.
- No new request is granted in a RESP cycle, even when the response is accepted in that cycle.

General rules:
- The ALU drive outputs always reflect the operand registers and hold their last values outside EXEC.
- req_ready is 0 in EXEC and RESP.
- Op codes are passed through unfiltered: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT unsigned. Any other code yields result 0 and zero 1, as the ALU defines.
- Requesters must hold req_valid and operands stable until req_ready. The arbiter samples them only in the grant cycle.
- Reset values: state IDLE, rr_ptr 0, grant_id 0, req_ready 0, rsp_valid 0, rsp_result 0, rsp_zero 0, operand registers 0, alu_control 3'b000, busy 0.
- Reset asserted mid-operation discards the in-flight operation; no response is delivered.
- An out-of-range N_REQ is a parameter error; the elaboration-time check fails.

## Timing

- Grant to rsp_valid: 2 edges. Grant is on edge 0, in IDLE; result is captured on edge 1, at the end of EXEC; rsp_valid is seen high from cycle 2.
- Minimum issue interval per operation is 3 cycles: IDLE, EXEC, RESP with immediate accept.
- Worst-case grant wait with continuous requests is (N_REQ-1) operations.
- rsp_result and rsp_zero stay stable from capture until the next EXEC capture.

## Structure

- The shared package alu_pkg holds:
  - alu_op_t, a 3-bit typedef;
  - the localparams ALU_ADD, ALU_SUB, ALU_AND, ALU_OR and ALU_SLT;
  - the arb_state_t enum {IDLE, EXEC, RESP}.
- One sub-module, rr_arbiter: combinational. It takes the valid vector and rr_ptr, and produces a one-hot grant plus a grant index and any-valid flag. The FSM, operand, response and pointer registers live in alu_arbiter.

## Test plan

- Single request: req 0 asserts ADD with srcA=5, srcB=7. Required response: req_ready[0] in the same cycle, rsp_valid[0] 2 cycles later, rsp_result=12, rsp_zero=0, busy high for 2 cycles.
- Contention with N_REQ=2: both requesters hold valid continuously with SUB (9-9) and OR (0xF0|0x0F). Required response: grants alternate 0,1,0,1; results 0 with zero=1, and 0xFF with zero=0.
- Backpressure: rsp_ready[0] is held low for 5 cycles. Required response: rsp_valid[0] and the result stay stable, req 1 stays waiting with req_ready[1]=0, and req 1 is granted only in the cycle after the response is accepted.
- SLT and illegal op: SLT with srcA=3, srcB=4 gives result 1. Op 3'b011 gives result 0 with zero=1.
- Reset mid-EXEC: rst_n is pulsed low during EXEC. Required response: all outputs return to their reset values immediately, no rsp_valid ever appears, and rr_ptr=0, so req 0 wins the next contention.
- Wrap-around with N_REQ=4: requesters 3 and 0 are valid with rr_ptr=3. Required response: grant 3, then grant 0.
